// File: rtl/oric_tape_pkg.sv
// rtl/oric_tape_pkg.sv - shared Oric tape types and default timing thresholds
package oric_tape_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rec_state_t;

    typedef enum logic [1:0] {
        B0,
        B1,
        GAP,
        NONE
    } bit_class_t;

    localparam int DEF_CLK_HZ      = 24_000_000;
    localparam int DEF_MIN_US      = 100;
    localparam int DEF_BIT1_MAX_US = 520;
    localparam int DEF_GAP_US      = 2000;

endpackage

// File: rtl/tape_period_meter.sv
// rtl/tape_period_meter.sv - measures rising-edge periods of the tape line in us and classifies them
module tape_period_meter
    import oric_tape_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int MIN_US      = DEF_MIN_US,
    parameter int BIT1_MAX_US = DEF_BIT1_MAX_US,
    parameter int GAP_US      = DEF_GAP_US
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tape_out,
    output logic       bit_valid,
    output bit_class_t bit_class
);

    localparam int DIV   = CLK_HZ / 1_000_000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(GAP_US + 2);

    logic [2:0]       sync;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] us_cnt;
    logic             armed;
    logic             rise;
    logic             tick;
    logic             sat;

    assign rise = sync[1] & ~sync[2];
    assign tick = (pre == PRE_W'(DIV - 1));
    assign sat  = (us_cnt == CNT_W'(GAP_US + 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '0;
            pre       <= '0;
            us_cnt    <= '0;
            armed     <= 1'b0;
            bit_valid <= 1'b0;
            bit_class <= NONE;
        end else begin
            sync      <= {sync[1:0], tape_out};
            pre       <= tick ? '0 : pre + PRE_W'(1);
            bit_valid <= 1'b0;
            bit_class <= NONE;
            if (!en) begin
                us_cnt <= '0;
                armed  <= 1'b0;
            end else if (rise && us_cnt >= CNT_W'(MIN_US)) begin
                // the first edge after a gap or enable only sets the period reference
                us_cnt <= '0;
                armed  <= 1'b1;
                if (armed && !sat) begin
                    bit_valid <= 1'b1;
                    bit_class <= (us_cnt <= CNT_W'(BIT1_MAX_US)) ? B1 : B0;
                end
            end else if (tick && !sat) begin
                us_cnt <= us_cnt + CNT_W'(1);
                if (us_cnt == CNT_W'(GAP_US)) begin
                    bit_valid <= 1'b1;
                    bit_class <= GAP;
                    armed     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cassette_recorder.sv
// rtl/cassette_recorder.sv - decodes framed tape bytes and appends them to the tape cache
module cassette_recorder
    import oric_tape_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int MIN_US      = DEF_MIN_US,
    parameter int BIT1_MAX_US = DEF_BIT1_MAX_US,
    parameter int GAP_US      = DEF_GAP_US,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              tape_out,
    input  logic              rewind,
    output logic [ADDR_W-1:0] tape_addr,
    output logic [7:0]        tape_dout,
    output logic              tape_wr,
    output logic [ADDR_W-1:0] tape_end,
    output logic              has_data,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow
);

    logic       bit_valid;
    bit_class_t bit_class;

    rec_state_t state, state_n;
    logic [7:0] shreg, shreg_n;
    logic [2:0] bcnt, bcnt_n;
    logic       full;
    logic       b;
    logic       do_write;
    logic       set_perr;
    logic       set_ferr;

    tape_period_meter #(
        .CLK_HZ      (CLK_HZ),
        .MIN_US      (MIN_US),
        .BIT1_MAX_US (BIT1_MAX_US),
        .GAP_US      (GAP_US)
    ) u_meter (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .tape_out  (tape_out),
        .bit_valid (bit_valid),
        .bit_class (bit_class)
    );

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bcnt_n   = bcnt;
        do_write = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        b        = (bit_class == B1);
        if (!en) begin
            state_n = IDLE;
        end else if (bit_valid) begin
            if (bit_class == GAP) begin
                state_n = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!b) begin
                            state_n = DATA;
                            bcnt_n  = '0;
                        end
                    end
                    DATA: begin
                        shreg_n = {b, shreg[7:1]};
                        bcnt_n  = bcnt + 3'd1;
                        if (bcnt == 3'd7) state_n = PARITY;
                    end
                    PARITY: begin
                        if (b != ~^shreg) set_perr = 1'b1;
                        state_n = STOP;
                    end
                    STOP: begin
                        if (b) do_write = 1'b1;
                        else   set_ferr = 1'b1;
                        state_n = IDLE;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bcnt       <= '0;
            tape_addr  <= '0;
            tape_dout  <= '0;
            tape_wr    <= 1'b0;
            tape_end   <= '0;
            has_data   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            full       <= 1'b0;
        end else if (rewind) begin
            state      <= IDLE;
            tape_addr  <= '0;
            tape_wr    <= 1'b0;
            tape_end   <= '0;
            has_data   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            full       <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bcnt    <= bcnt_n;
            tape_wr <= 1'b0;
            if (set_perr) parity_err <= 1'b1;
            if (set_ferr) frame_err  <= 1'b1;
            if (do_write) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    tape_wr   <= 1'b1;
                    tape_dout <= shreg;
                end
            end
            // address advances the cycle after the strobe; it parks on the last location
            if (tape_wr) begin
                tape_end <= tape_addr;
                has_data <= 1'b1;
                if (&tape_addr) full <= 1'b1;
                else            tape_addr <= tape_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cassette_recorder.sv
// tb/tb_cassette_recorder.sv - randomized bench for cassette_recorder with a bit-level frame model
`timescale 1ns/1ps
module tb_cassette_recorder;

    localparam int CLK_HZ      = 2_000_000;
    localparam int MIN_US      = 5;
    localparam int BIT1_MAX_US = 26;
    localparam int GAP_US      = 100;
    localparam int ADDR_W      = 4;
    localparam int US          = 20;
    localparam int P1          = 21;
    localparam int P0          = 31;
    localparam int ADDR_MAX    = (1 << ADDR_W) - 1;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              en       = 1'b0;
    logic              tape_out = 1'b0;
    logic              rewind   = 1'b0;
    logic [ADDR_W-1:0] tape_addr;
    logic [7:0]        tape_dout;
    logic              tape_wr;
    logic [ADDR_W-1:0] tape_end;
    logic              has_data;
    logic              parity_err;
    logic              frame_err;
    logic              overflow;

    int  total = 0;
    int  bad   = 0;
    int  m_addr = 0, m_end = 0, m_nwr = 0;
    bit  m_has = 0, m_perr = 0, m_ferr = 0, m_ovf = 0, m_full = 0, m_armed = 0;
    bit  frame[$];
    int  exp_q[$];
    int  wr_count = 0, last_wr_addr = 0, last_wr_data = 0, e;
    time last_edge = 0;

    always #5 clk = ~clk;

    cassette_recorder #(
        .CLK_HZ      (CLK_HZ),
        .MIN_US      (MIN_US),
        .BIT1_MAX_US (BIT1_MAX_US),
        .GAP_US      (GAP_US),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .tape_out   (tape_out),
        .rewind     (rewind),
        .tape_addr  (tape_addr),
        .tape_dout  (tape_dout),
        .tape_wr    (tape_wr),
        .tape_end   (tape_end),
        .has_data   (has_data),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // model: frames are collected as a list of bits, start bit first
    function automatic void m_rewind();
        frame.delete();
        m_addr = 0; m_end = 0; m_has = 0;
        m_perr = 0; m_ferr = 0; m_ovf = 0; m_full = 0;
    endfunction

    function automatic void m_write(int d);
        if (m_full) begin
            m_ovf = 1;
        end else begin
            exp_q.push_back((m_addr << 8) | d);
            m_nwr++;
            m_end = m_addr;
            m_has = 1;
            if (m_addr == ADDR_MAX) m_full = 1;
            else m_addr++;
        end
    endfunction

    function automatic void m_bit(bit b);
        int d = 0;
        int ones = 0;
        if (frame.size() == 0 && b) return;
        frame.push_back(b);
        if (frame.size() == 10) begin
            for (int i = 1; i <= 8; i++) ones += int'(frame[i]);
            if (b != (ones % 2 == 0)) m_perr = 1;
        end
        if (frame.size() == 11) begin
            for (int i = 0; i < 8; i++) d |= int'(frame[i + 1]) << i;
            if (b) m_write(d);
            else m_ferr = 1;
            frame.delete();
        end
    endfunction

    function automatic void m_edge(int us);
        if (us > GAP_US) begin
            frame.delete();
            m_armed = 1;
        end else if (!m_armed) begin
            m_armed = 1;
        end else begin
            m_bit(us <= BIT1_MAX_US);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && tape_wr) begin
            wr_count++;
            last_wr_addr = int'(tape_addr);
            last_wr_data = int'(tape_dout);
            chk("wr_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", tape_addr, e >> 8);
                chk("wr_data", tape_dout, e & 255);
            end
        end
    end

    // one rising-edge period; optional early glitch edge, optional rewind on the closing edge
    task automatic period(int us, bit gl, bit rew);
        if (gl) begin
            #(US) tape_out = 1'b0;
            #(US) tape_out = 1'b1;
            #((us / 2 - 2) * US) tape_out = 1'b0;
        end else begin
            #((us / 2) * US) tape_out = 1'b0;
        end
        #((us - us / 2) * US) tape_out = 1'b1;
        if (rew) begin
            rewind = 1'b1;
            m_rewind();
        end
        m_edge(int'(($time - last_edge) / US));
        last_edge = $time;
        if (rew) begin
            repeat (6) @(negedge clk);
            rewind = 1'b0;
        end
    endtask

    task automatic resync();
        period(GAP_US + 20, 1'b0, 1'b0);
    endtask

    task automatic leader(int n);
        repeat (n) period(P1, 1'b0, 1'b0);
    endtask

    task automatic send_byte(logic [7:0] d, bit bad_par, bit bad_stop, bit gl, bit rew);
        logic par;
        par = (~^d) ^ bad_par;
        period(P0, gl, 1'b0);
        for (int i = 0; i < 8; i++) period(d[i] ? P1 : P0, gl, 1'b0);
        period(par ? P1 : P0, gl, 1'b0);
        period(bad_stop ? P0 : P1, gl, rew);
    endtask

    task automatic pulse_rewind();
        @(negedge clk) rewind = 1'b1;
        m_rewind();
        repeat (3) @(negedge clk);
        rewind = 1'b0;
    endtask

    task automatic check_state(string tag);
        repeat (12) @(negedge clk);
        chk($sformatf("%s.addr", tag), tape_addr, m_addr);
        chk($sformatf("%s.end", tag), tape_end, m_end);
        chk($sformatf("%s.has", tag), has_data, m_has);
        chk($sformatf("%s.perr", tag), parity_err, m_perr);
        chk($sformatf("%s.ferr", tag), frame_err, m_ferr);
        chk($sformatf("%s.ovf", tag), overflow, m_ovf);
        chk($sformatf("%s.nwr", tag), wr_count, m_nwr);
    endtask

    task automatic check_zero(string tag);
        chk($sformatf("%s.addr0", tag), tape_addr, 0);
        chk($sformatf("%s.end0", tag), tape_end, 0);
        chk($sformatf("%s.wr0", tag), tape_wr, 0);
        chk($sformatf("%s.has0", tag), has_data, 0);
        chk($sformatf("%s.perr0", tag), parity_err, 0);
        chk($sformatf("%s.ferr0", tag), frame_err, 0);
        chk($sformatf("%s.ovf0", tag), overflow, 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        en = 1'b1;
        last_edge = $time;

        resync(); leader(4);
        send_byte(8'h16, 0, 0, 0, 0);
        check_state("single");
        chk("single.wr_addr", last_wr_addr, 0);
        chk("single.wr_data", last_wr_data, 8'h16);
        chk("single.end_lit", tape_end, 0);
        chk("single.has_lit", has_data, 1);

        pulse_rewind();
        resync(); leader(3);
        send_byte(8'h16, 0, 0, 0, 0);
        send_byte(8'h16, 0, 0, 0, 0);
        send_byte(8'h24, 0, 0, 0, 0);
        check_state("b2b");
        chk("b2b.end_lit", tape_end, 2);
        chk("b2b.flags_lit", {parity_err, frame_err, overflow}, 0);

        send_byte(8'h24, 1, 0, 0, 0);
        send_byte(8'h5A, 0, 1, 0, 0);
        check_state("errs");
        chk("errs.perr_lit", parity_err, 1);
        chk("errs.ferr_lit", frame_err, 1);
        chk("errs.data_lit", last_wr_data, 8'h24);
        chk("errs.addr_lit", tape_addr, 4);

        resync(); leader(2);
        send_byte(8'hA5, 0, 0, 1, 0);
        period(P0, 0, 0);
        for (int i = 0; i < 4; i++) period(P1, 0, 0);
        period(GAP_US + 50, 0, 0);
        leader(2);
        send_byte(8'h3C, 0, 0, 0, 0);
        check_state("glitch_gap");
        chk("glitch_gap.end_lit", tape_end, 5);
        chk("glitch_gap.data_lit", last_wr_data, 8'h3C);

        resync(); leader(2);
        for (int i = 0; i < 3; i++) period(P0, 0, 0);
        @(negedge clk) en = 1'b0;
        frame.delete(); m_armed = 0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        chk("endrop.addr_kept", tape_addr, 6);
        resync(); leader(2);
        send_byte(8'h81, 0, 0, 0, 0);
        check_state("endrop");
        chk("endrop.end_lit", tape_end, 6);

        resync(); leader(2);
        send_byte(8'h77, 0, 0, 0, 1);
        check_state("rewind");
        chk("rewind.addr_lit", tape_addr, 0);
        chk("rewind.has_lit", has_data, 0);

        resync(); leader(2);
        for (int k = 0; k < 40 && m_addr < ADDR_MAX - 1; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 6)) period(P0, 0, 0);
                period(GAP_US + 30, 0, 0);
            end
            leader($urandom_range(1, 3));
            send_byte(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 3) == 0, 0);
        end
        check_state("random");
        chk("random.addr_lit", tape_addr, ADDR_MAX - 1);
        for (int i = 0; i < 3; i++) begin
            leader(1);
            send_byte(8'($urandom), 0, 0, 0, 0);
        end
        check_state("full");
        chk("full.ovf_lit", overflow, 1);
        chk("full.addr_lit", tape_addr, ADDR_MAX);
        chk("full.end_lit", tape_end, ADDR_MAX);
        chk("full.last_wr_lit", last_wr_addr, ADDR_MAX);

        resync(); leader(2);
        for (int i = 0; i < 4; i++) period(P0, 0, 0);
        @(negedge clk) reset = 1'b1;
        m_rewind(); m_armed = 0;
        repeat (3) @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        resync(); leader(2);
        send_byte(8'h42, 0, 0, 0, 0);
        check_state("after_reset");
        chk("after_reset.wr_addr", last_wr_addr, 0);
        chk("after_reset.wr_data", last_wr_data, 8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
